// File: rtl/sensor_input_conditioner.sv
// Input stage for the cabin-safety board switches: 2-FF sync, per-bit debounce, update pulse and handshake.
// Optional periodic forced refresh when PERIODIC_READY_EN is defined.
module sensor_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int REFRESH_TICKS   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Temperatura,
  input  logic       Presencia,
  input  logic       Ignicion,
  input  logic       dato_ack,
  output logic [4:0] Temperatura_sync,
  output logic       Presencia_sync,
  output logic       Ignicion_sync,
  output logic       dato_listo,
  output logic       dato_valido
);

  localparam int N = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (CNT_W < $clog2(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (REFRESH_TICKS < 1) begin : g_bad_refresh
    $error("REFRESH_TICKS must be at least 1");
  end

  logic [N-1:0]     raw;
  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     stable;
  logic [N-1:0]     stable_next;
  logic [CNT_W-1:0] cnt      [N];
  logic [CNT_W-1:0] cnt_next [N];
  logic             change_upd;
  logic             upd;

  assign raw = {Ignicion, Presencia, Temperatura};

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    stable_next = stable;
    change_upd  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_next[i] = s2[i];
          change_upd     = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef PERIODIC_READY_EN
  localparam int REF_W = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_TICKS - 1);

  logic [REF_W-1:0] ref_cnt;
  logic             ref_wrap;

  assign ref_wrap = (ref_cnt == REF_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign upd = change_upd | ref_wrap;
`else
  assign upd = change_upd;
`endif

  // An update in the same cycle as an ack keeps the pending flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      stable      <= '0;
      dato_listo  <= 1'b0;
      dato_valido <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1         <= raw;
      s2         <= s1;
      stable     <= stable_next;
      dato_listo <= upd;
      if (upd) begin
        dato_valido <= 1'b1;
      end else if (dato_ack) begin
        dato_valido <= 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign Temperatura_sync = stable[4:0];
  assign Presencia_sync   = stable[5];
  assign Ignicion_sync    = stable[6];

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Scoreboard bench for sensor_input_conditioner with DEBOUNCE_CYCLES=4, REFRESH_TICKS=16.
module tb_sensor_input_conditioner;

  localparam int DEB     = 4;
  localparam int LATENCY = DEB + 2;

  logic       clk;
  logic       rst;
  logic [4:0] Temperatura;
  logic       Presencia;
  logic       Ignicion;
  logic       dato_ack;
  logic [4:0] Temperatura_sync;
  logic       Presencia_sync;
  logic       Ignicion_sync;
  logic       dato_listo;
  logic       dato_valido;

  int checks = 0;
  int errors = 0;

  logic [6:0] sb_q [$];
  logic [6:0] exp_v;
  logic [6:0] got_v;
  int         edges;

  sensor_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .REFRESH_TICKS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Temperatura(Temperatura),
    .Presencia(Presencia),
    .Ignicion(Ignicion),
    .dato_ack(dato_ack),
    .Temperatura_sync(Temperatura_sync),
    .Presencia_sync(Presencia_sync),
    .Ignicion_sync(Ignicion_sync),
    .dato_listo(dato_listo),
    .dato_valido(dato_valido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle at the falling edge where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns the number of rising edges until dato_listo is seen, 0 if the bound expires.
  task automatic wait_update(input int max_edges, output int n_edges);
    n_edges = 0;
    for (int n = 1; n <= max_edges; n++) begin
      step();
      if (dato_listo && n_edges == 0) begin
        n_edges = n;
        break;
      end
    end
  endtask

  task automatic pulse_ack();
    dato_ack = 1'b1;
    step();
    dato_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Temperatura = 5'd31;
    step();
    step();
    checks++;
    if ({Temperatura_sync, Presencia_sync, Ignicion_sync, dato_listo, dato_valido} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b exp=0", {Temperatura_sync, Presencia_sync, Ignicion_sync, dato_listo, dato_valido});
    end
    sb_q.push_back({1'b0, 1'b0, 5'd31});
    rst = 1'b0;
    wait_update(10, edges);
    checks++;
    if (edges != LATENCY) begin
      errors++;
      $display("[TB] FAIL reset_latency got=%0d exp=%0d", edges, LATENCY);
    end
    exp_v = sb_q.pop_front();
    got_v = {Ignicion_sync, Presencia_sync, Temperatura_sync};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_vector got=%h exp=%h", got_v, exp_v);
    end
    pulse_ack();
  endtask

  task automatic test_clean_step();
    Temperatura = 5'd0;
    sb_q.push_back({1'b0, 1'b0, 5'd0});
    wait_update(10, edges);
    exp_v = sb_q.pop_front();
    got_v = {Ignicion_sync, Presencia_sync, Temperatura_sync};
    checks++;
    if (edges == 0 || got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL step_to_zero got=%h exp=%h edges=%0d", got_v, exp_v, edges);
    end
    pulse_ack();
    Temperatura = 5'd25;
    sb_q.push_back({1'b0, 1'b0, 5'd25});
    wait_update(10, edges);
    checks++;
    if (edges != LATENCY) begin
      errors++;
      $display("[TB] FAIL step_latency got=%0d exp=%0d", edges, LATENCY);
    end
    exp_v = sb_q.pop_front();
    got_v = {Ignicion_sync, Presencia_sync, Temperatura_sync};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL step_vector got=%h exp=%h", got_v, exp_v);
    end
    step();
    checks++;
    if (dato_listo !== 1'b0 || dato_valido !== 1'b1) begin
      errors++;
      $display("[TB] FAIL step_single_pulse got listo=%b valido=%b exp listo=0 valido=1", dato_listo, dato_valido);
    end
    repeat (3) step();
    checks++;
    if (dato_valido !== 1'b1) begin
      errors++;
      $display("[TB] FAIL step_valido_held got=%b exp=1", dato_valido);
    end
    pulse_ack();
    checks++;
    if (dato_valido !== 1'b0) begin
      errors++;
      $display("[TB] FAIL step_ack_clear got=%b exp=0", dato_valido);
    end
    pulse_ack();
    checks++;
    if (dato_valido !== 1'b0 || Temperatura_sync !== 5'd25) begin
      errors++;
      $display("[TB] FAIL idle_ack got valido=%b temp=%0d exp valido=0 temp=25", dato_valido, Temperatura_sync);
    end
  endtask

  task automatic test_bounce();
    int bad = 0;
    int pulses = 0;
    for (int k = 0; k < 10; k++) begin
      Presencia = ~Presencia;
      repeat (2) begin
        step();
        if (Presencia_sync !== 1'b0) bad++;
        if (dato_listo) pulses++;
      end
    end
    checks++;
    if (bad != 0 || pulses != 0) begin
      errors++;
      $display("[TB] FAIL bounce_rejected got bad=%0d pulses=%0d exp 0 0", bad, pulses);
    end
    Presencia = 1'b1;
    sb_q.push_back({1'b0, 1'b1, 5'd25});
    wait_update(10, edges);
    checks++;
    if (edges != LATENCY) begin
      errors++;
      $display("[TB] FAIL bounce_latency got=%0d exp=%0d", edges, LATENCY);
    end
    exp_v = sb_q.pop_front();
    got_v = {Ignicion_sync, Presencia_sync, Temperatura_sync};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL bounce_vector got=%h exp=%h", got_v, exp_v);
    end
    pulses = 0;
    repeat (8) begin
      step();
      if (dato_listo) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL bounce_one_pulse got extra=%0d exp=0", pulses);
    end
    pulse_ack();
  endtask

  task automatic test_ack_collision();
    Temperatura = 5'd7;
    sb_q.push_back({1'b0, 1'b1, 5'd7});
    wait_update(10, edges);
    exp_v = sb_q.pop_front();
    got_v = {Ignicion_sync, Presencia_sync, Temperatura_sync};
    checks++;
    if (edges == 0 || got_v !== exp_v || dato_valido !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_setup got=%h valido=%b exp=%h valido=1", got_v, dato_valido, exp_v);
    end
    Ignicion = 1'b1;
    sb_q.push_back({1'b1, 1'b1, 5'd7});
    repeat (LATENCY - 1) step();
    dato_ack = 1'b1;
    step();
    dato_ack = 1'b0;
    exp_v = sb_q.pop_front();
    got_v = {Ignicion_sync, Presencia_sync, Temperatura_sync};
    checks++;
    if (dato_listo !== 1'b1 || got_v !== exp_v || dato_valido !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_upd_wins got listo=%b vec=%h valido=%b exp listo=1 vec=%h valido=1",
               dato_listo, got_v, dato_valido, exp_v);
    end
    pulse_ack();
    checks++;
    if (dato_valido !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collide_second_ack got=%b exp=0", dato_valido);
    end
  endtask

  task automatic test_reset_mid();
    Presencia = 1'b0;
    sb_q.push_back({1'b1, 1'b0, 5'd7});
    wait_update(10, edges);
    exp_v = sb_q.pop_front();
    got_v = {Ignicion_sync, Presencia_sync, Temperatura_sync};
    checks++;
    if (edges == 0 || got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL mid_setup got=%h exp=%h", got_v, exp_v);
    end
    pulse_ack();
    Presencia = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({Temperatura_sync, Presencia_sync, Ignicion_sync, dato_listo, dato_valido} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs got=%b exp=0", {Temperatura_sync, Presencia_sync, Ignicion_sync, dato_listo, dato_valido});
    end
    sb_q.push_back({1'b1, 1'b1, 5'd7});
    wait_update(10, edges);
    checks++;
    if (edges != LATENCY) begin
      errors++;
      $display("[TB] FAIL mid_latency got=%0d exp=%0d", edges, LATENCY);
    end
    exp_v = sb_q.pop_front();
    got_v = {Ignicion_sync, Presencia_sync, Temperatura_sync};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL mid_vector got=%h exp=%h", got_v, exp_v);
    end
    pulse_ack();
  endtask

  task automatic test_refresh();
    int pulses = 0;
`ifdef PERIODIC_READY_EN
    int first = 0;
    int second = 0;
    wait_update(20, first);
    wait_update(20, second);
    checks++;
    if (first == 0 || second != 16) begin
      errors++;
      $display("[TB] FAIL refresh_period got first=%0d interval=%0d exp interval=16", first, second);
    end
`else
    repeat (40) begin
      step();
      if (dato_listo) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL refresh_absent got pulses=%0d exp=0", pulses);
    end
`endif
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drained got=%0d exp=0", sb_q.size());
    end
    pulses = 0;
  endtask

  initial begin
    rst = 1'b1;
    Temperatura = 5'd0;
    Presencia = 1'b0;
    Ignicion = 1'b0;
    dato_ack = 1'b0;
    @(negedge clk);
    $display("[TB] start");
    test_reset();
    test_clean_step();
    test_bounce();
    test_ack_collision();
    test_reset_mid();
    test_refresh();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
